// File: rtl/pmp_check_sched_if.sv
// Request/response channels between the fetch and LSU front ends and the PMP checker.
// The checker side uses the slave modport; the requesters and stall/trap logic use master.
interface pmp_check_sched_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic        priv_m;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_src;
  logic        resp_allow;
  logic        resp_matched;
  logic [3:0]  resp_idx;

  modport master (
    output if_req_valid, if_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_we,
           priv_m, resp_ready,
    input  if_req_ready, lsu_req_ready, resp_valid, resp_src, resp_allow,
           resp_matched, resp_idx
  );

  modport slave (
    input  if_req_valid, if_req_addr, lsu_req_valid, lsu_req_addr, lsu_req_we,
           priv_m, resp_ready,
    output if_req_ready, lsu_req_ready, resp_valid, resp_src, resp_allow,
           resp_matched, resp_idx
  );
endinterface

// File: rtl/pmp_check_sched.sv
// Sequential PMP checker shared by fetch and LSU: round-robin accept, ENTRIES_PER_BEAT entries per cycle.
// Define PMP_NAPOT_EN to enable NAPOT matching; otherwise NAPOT entries behave as OFF.
module pmp_check_sched #(
  parameter int NUM_ENTRIES      = 16,
  parameter int ENTRIES_PER_BEAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pmp_check_sched_if.slave          bus,
  input  logic [NUM_ENTRIES*8-1:0]  pmpcfg_i,
  input  logic [NUM_ENTRIES*32-1:0] pmpaddr_i,
  output logic                      scan_busy
);
  localparam int NUM_BEATS = NUM_ENTRIES / ENTRIES_PER_BEAT;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       req_addr;
  logic              req_src;
  logic [2:0]        req_perm;
  logic              req_priv;
  logic              last_src;

  // Per-entry view: cfg packed as {L, A[1:0], X, W, R}; prev is the TOR lower bound.
  logic [5:0]  cfg_arr  [NUM_ENTRIES];
  logic [31:0] addr_arr [NUM_ENTRIES];
  logic [31:0] prev_arr [NUM_ENTRIES];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_unpack
    logic cfg_unused;
    assign cfg_unused  = ^pmpcfg_i[8*i+5 +: 2];
    assign cfg_arr[i]  = {pmpcfg_i[8*i+7], pmpcfg_i[8*i+3 +: 2], pmpcfg_i[8*i +: 3]};
    assign addr_arr[i] = pmpaddr_i[32*i +: 32];
    if (i == 0) begin : g_first
      assign prev_arr[i] = '0;
    end else begin : g_rest
      assign prev_arr[i] = pmpaddr_i[32*(i-1) +: 32];
    end
  end

  function automatic logic entry_match(input logic [1:0]  a,
                                       input logic [31:0] pa,
                                       input logic [31:0] prev,
                                       input logic [31:0] addr);
    logic [33:0] a34;
    logic        m;
`ifdef PMP_NAPOT_EN
    logic [31:0] napot_mask;
`endif
    a34 = {2'b00, addr};
    m   = 1'b0;
    case (a)
      A_TOR:   m = ({prev, 2'b00} <= a34) && (a34 < {pa, 2'b00});
      A_NA4:   m = (addr[31:2] == pa[29:0]);
`ifdef PMP_NAPOT_EN
      // Trailing ones plus the first zero mark the don't-care low bits of the region.
      A_NAPOT: begin
        napot_mask = pa ^ (pa + 32'd1);
        m = (((a34[33:2] ^ pa) & ~napot_mask) == 32'd0);
      end
`endif
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic [5:0]                  lane_cfg  [ENTRIES_PER_BEAT];
  logic [31:0]                 lane_pa   [ENTRIES_PER_BEAT];
  logic [31:0]                 lane_prev [ENTRIES_PER_BEAT];
  logic [ENTRIES_PER_BEAT-1:0] lane_hit;

  always_comb begin
    for (int j = 0; j < ENTRIES_PER_BEAT; j++) begin
      lane_cfg[j]  = '0;
      lane_pa[j]   = '0;
      lane_prev[j] = '0;
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat == BEAT_W'(b)) begin
          lane_cfg[j]  = cfg_arr[b*ENTRIES_PER_BEAT + j];
          lane_pa[j]   = addr_arr[b*ENTRIES_PER_BEAT + j];
          lane_prev[j] = prev_arr[b*ENTRIES_PER_BEAT + j];
        end
      end
      lane_hit[j] = entry_match(lane_cfg[j][4:3], lane_pa[j], lane_prev[j], req_addr);
    end
  end

  logic       hit_any;
  logic       hit_lock;
  logic [2:0] hit_perm;
  logic [3:0] hit_idx;
  logic       allow_hit;
  int         hit_lane;

  // Walk lanes downward so the lowest-index match in the beat wins.
  always_comb begin
    hit_any  = |lane_hit;
    hit_lock = 1'b0;
    hit_perm = '0;
    hit_lane = 0;
    for (int j = ENTRIES_PER_BEAT - 1; j >= 0; j--) begin
      if (lane_hit[j]) begin
        hit_lane = j;
        hit_lock = lane_cfg[j][5];
        hit_perm = lane_cfg[j][2:0];
      end
    end
    hit_idx   = 4'(32'(beat) * ENTRIES_PER_BEAT + hit_lane);
    allow_hit = (!hit_lock && req_priv) || (|(hit_perm & req_perm));
  end

  logic can_accept;
  logic grant_if;
  logic grant_lsu;
  logic last_beat;

  assign can_accept        = (state == IDLE) && rst_n;
  assign grant_if          = can_accept && bus.if_req_valid  && (!bus.lsu_req_valid || last_src);
  assign grant_lsu         = can_accept && bus.lsu_req_valid && (!bus.if_req_valid  || !last_src);
  assign bus.if_req_ready  = grant_if;
  assign bus.lsu_req_ready = grant_lsu;
  assign scan_busy         = (state != IDLE);
  assign last_beat         = (beat == BEAT_W'(NUM_BEATS - 1));

  // Request capture, beat sequencing and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      beat             <= '0;
      req_addr         <= '0;
      req_src          <= 1'b0;
      req_perm         <= '0;
      req_priv         <= 1'b0;
      last_src         <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_src     <= 1'b0;
      bus.resp_allow   <= 1'b0;
      bus.resp_matched <= 1'b0;
      bus.resp_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_lsu) begin
            req_src  <= grant_lsu;
            req_addr <= grant_lsu ? bus.lsu_req_addr : bus.if_req_addr;
            req_perm <= grant_lsu ? (bus.lsu_req_we ? 3'b010 : 3'b001) : 3'b100;
            req_priv <= bus.priv_m;
            beat     <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (hit_any) begin
            bus.resp_valid   <= 1'b1;
            bus.resp_src     <= req_src;
            bus.resp_matched <= 1'b1;
            bus.resp_idx     <= hit_idx;
            bus.resp_allow   <= allow_hit;
            state            <= RESP;
          end else if (last_beat) begin
            bus.resp_valid   <= 1'b1;
            bus.resp_src     <= req_src;
            bus.resp_matched <= 1'b0;
            bus.resp_idx     <= '0;
            bus.resp_allow   <= req_priv;
            state            <= RESP;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            last_src       <= req_src;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmp_check_sched.sv
// Directed bench for pmp_check_sched: NA4/TOR/NAPOT matching, privilege rules, latency,
// round-robin arbitration and mid-scan reset, with hand-computed expectations.
module tb_pmp_check_sched;
  localparam int NE = 16;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NE*8-1:0]  pmpcfg;
  logic [NE*32-1:0] pmpaddr;
  logic            scan_busy;
  int              checks = 0;
  int              fails  = 0;

  pmp_check_sched_if pif ();

  pmp_check_sched #(.NUM_ENTRIES(NE), .ENTRIES_PER_BEAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (pif.slave),
    .pmpcfg_i  (pmpcfg),
    .pmpaddr_i (pmpaddr),
    .scan_busy (scan_busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [7:0] cfg, input logic [31:0] addr);
    pmpcfg[8*i +: 8]   = cfg;
    pmpaddr[32*i +: 32] = addr;
  endtask

  // Issue one request and return with the response sitting on the bus at a negedge.
  task automatic apply_stimulus(input string tag, input logic src, input logic [31:0] addr,
                                input logic we, input logic priv, output int lat);
    @(negedge clk);
    pif.priv_m = priv;
    if (src) begin
      pif.lsu_req_valid = 1'b1;
      pif.lsu_req_addr  = addr;
      pif.lsu_req_we    = we;
    end else begin
      pif.if_req_valid = 1'b1;
      pif.if_req_addr  = addr;
    end
    #1;
    check_output({tag, "_ready"}, 32'(src ? pif.lsu_req_ready : pif.if_req_ready), 1);
    @(posedge clk);
    #1;
    pif.if_req_valid  = 1'b0;
    pif.lsu_req_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (pif.resp_valid) break;
      @(posedge clk);
      lat++;
    end
    check_output({tag, "_valid"}, 32'(pif.resp_valid), 1);
  endtask

  task automatic finish_resp(input string tag);
    pif.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    pif.resp_ready = 1'b0;
    check_output({tag, "_drop"}, 32'(pif.resp_valid), 0);
  endtask

  task automatic expect_resp(input string tag, input int lat, input int exp_lat, input logic src,
                             input logic matched, input logic allow, input logic [3:0] idx);
    check_output({tag, "_lat"},     lat, exp_lat);
    check_output({tag, "_src"},     32'(pif.resp_src), 32'(src));
    check_output({tag, "_matched"}, 32'(pif.resp_matched), 32'(matched));
    check_output({tag, "_allow"},   32'(pif.resp_allow), 32'(allow));
    check_output({tag, "_idx"},     32'(pif.resp_idx), 32'(idx));
  endtask

  initial begin
    int   lat;
    int   n_resp;
    int   t_log [4];
    logic src_log [4];
    logic seen;

    pif.if_req_valid  = 1'b0;
    pif.if_req_addr   = '0;
    pif.lsu_req_valid = 1'b0;
    pif.lsu_req_addr  = '0;
    pif.lsu_req_we    = 1'b0;
    pif.priv_m        = 1'b0;
    pif.resp_ready    = 1'b0;
    pmpcfg            = '0;
    pmpaddr           = '0;
    for (int i = 0; i < 4; i++) begin
      t_log[i]   = 0;
      src_log[i] = 1'bx;
    end

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    check_output("rst_resp_valid", 32'(pif.resp_valid), 0);
    check_output("rst_allow",      32'(pif.resp_allow), 0);
    check_output("rst_matched",    32'(pif.resp_matched), 0);
    check_output("rst_src",        32'(pif.resp_src), 0);
    check_output("rst_idx",        32'(pif.resp_idx), 0);
    check_output("rst_busy",       32'(scan_busy), 0);
    check_output("rst_if_ready",   32'(pif.if_req_ready), 0);
    check_output("rst_lsu_ready",  32'(pif.lsu_req_ready), 0);
    rst_n = 1'b1;
    #1;
    pif.if_req_valid = 1'b1;
    #1;
    check_output("comb_if_ready", 32'(pif.if_req_ready), 1);
    pif.if_req_valid = 1'b0;
    #1;
    check_output("comb_if_drop", 32'(pif.if_req_ready), 0);

    $display("[TB] NA4 entry 0, read only");
    set_entry(0, 8'h11, 32'h0000_0400);
    apply_stimulus("na4_load_u", 1'b1, 32'h1000, 1'b0, 1'b0, lat);
    expect_resp("na4_load_u", lat, 2, 1'b1, 1'b1, 1'b1, 4'd0);
    check_output("na4_busy", 32'(scan_busy), 1);
    @(negedge clk);
    check_output("na4_hold_valid", 32'(pif.resp_valid), 1);
    check_output("na4_hold_allow", 32'(pif.resp_allow), 1);
    finish_resp("na4_load_u");
    apply_stimulus("na4_store_u", 1'b1, 32'h1000, 1'b1, 1'b0, lat);
    expect_resp("na4_store_u", lat, 2, 1'b1, 1'b1, 1'b0, 4'd0);
    finish_resp("na4_store_u");
    apply_stimulus("na4_store_m", 1'b1, 32'h1000, 1'b1, 1'b1, lat);
    expect_resp("na4_store_m", lat, 2, 1'b1, 1'b1, 1'b1, 4'd0);
    finish_resp("na4_store_m");
    set_entry(0, 8'h91, 32'h0000_0400);
    apply_stimulus("na4_store_m_lock", 1'b1, 32'h1000, 1'b1, 1'b1, lat);
    expect_resp("na4_store_m_lock", lat, 2, 1'b1, 1'b1, 1'b0, 4'd0);
    finish_resp("na4_store_m_lock");

    $display("[TB] TOR entries 5 and 9");
    pmpcfg  = '0;
    pmpaddr = '0;
    set_entry(5, 8'h09, 32'h0000_2000);
    set_entry(8, 8'h00, 32'h0000_2000);
    set_entry(9, 8'h0C, 32'h0000_2400);
    apply_stimulus("tor_8800", 1'b0, 32'h8800, 1'b0, 1'b0, lat);
    expect_resp("tor_8800", lat, 4, 1'b0, 1'b1, 1'b1, 4'd9);
    finish_resp("tor_8800");
    apply_stimulus("tor_8000", 1'b0, 32'h8000, 1'b0, 1'b0, lat);
    expect_resp("tor_8000", lat, 4, 1'b0, 1'b1, 1'b1, 4'd9);
    finish_resp("tor_8000");
    apply_stimulus("tor_9000", 1'b0, 32'h9000, 1'b0, 1'b0, lat);
    expect_resp("tor_9000", lat, 5, 1'b0, 1'b0, 1'b0, 4'd0);
    finish_resp("tor_9000");
    apply_stimulus("tor_7ffc", 1'b0, 32'h7FFC, 1'b0, 1'b0, lat);
    expect_resp("tor_7ffc", lat, 3, 1'b0, 1'b1, 1'b0, 4'd5);
    finish_resp("tor_7ffc");

    $display("[TB] all entries OFF");
    pmpcfg  = '0;
    pmpaddr = '0;
    apply_stimulus("off_u", 1'b0, 32'h0, 1'b0, 1'b0, lat);
    expect_resp("off_u", lat, 5, 1'b0, 1'b0, 1'b0, 4'd0);
    finish_resp("off_u");
    apply_stimulus("off_m", 1'b0, 32'h0, 1'b0, 1'b1, lat);
    expect_resp("off_m", lat, 5, 1'b0, 1'b0, 1'b1, 4'd0);
    finish_resp("off_m");

    $display("[TB] NAPOT entry 3, 8 KiB at 0");
    set_entry(3, 8'h19, 32'h0000_03FF);
    apply_stimulus("napot_1ffc", 1'b1, 32'h1FFC, 1'b0, 1'b0, lat);
`ifdef PMP_NAPOT_EN
    expect_resp("napot_1ffc", lat, 2, 1'b1, 1'b1, 1'b1, 4'd3);
`else
    expect_resp("napot_1ffc", lat, 5, 1'b1, 1'b0, 1'b0, 4'd0);
`endif
    finish_resp("napot_1ffc");
    apply_stimulus("napot_2000", 1'b1, 32'h2000, 1'b0, 1'b0, lat);
    expect_resp("napot_2000", lat, 5, 1'b1, 1'b0, 1'b0, 4'd0);
    finish_resp("napot_2000");

    $display("[TB] reset during scan");
    pmpcfg  = '0;
    pmpaddr = '0;
    @(negedge clk);
    pif.if_req_valid = 1'b1;
    pif.if_req_addr  = 32'h0;
    pif.priv_m       = 1'b0;
    @(posedge clk);
    #1;
    pif.if_req_valid = 1'b0;
    @(negedge clk);
    check_output("mid_busy", 32'(scan_busy), 1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", 32'(scan_busy), 0);
    pif.if_req_valid = 1'b1;
    #1;
    check_output("mid_rst_ready", 32'(pif.if_req_ready), 0);
    pif.if_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    pif.if_req_valid = 1'b1;
    #1;
    check_output("mid_rel_ready", 32'(pif.if_req_ready), 1);
    pif.if_req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = seen | pif.resp_valid;
    end
    check_output("mid_no_resp", 32'(seen), 0);

    $display("[TB] round-robin with both requesters always valid");
    @(negedge clk);
    pif.priv_m        = 1'b1;
    pif.if_req_addr   = 32'h0;
    pif.lsu_req_addr  = 32'h0;
    pif.lsu_req_we    = 1'b0;
    pif.if_req_valid  = 1'b1;
    pif.lsu_req_valid = 1'b1;
    pif.resp_ready    = 1'b1;
    n_resp = 0;
    for (int c = 0; c < 60 && n_resp < 4; c++) begin
      @(negedge clk);
      if (pif.resp_valid) begin
        src_log[n_resp] = pif.resp_src;
        t_log[n_resp]   = c;
        n_resp++;
      end
    end
    @(negedge clk);
    pif.if_req_valid  = 1'b0;
    pif.lsu_req_valid = 1'b0;
    pif.resp_ready    = 1'b0;
    check_output("rr_count", n_resp, 4);
    check_output("rr_src0", 32'(src_log[0]), 0);
    check_output("rr_src1", 32'(src_log[1]), 1);
    check_output("rr_src2", 32'(src_log[2]), 0);
    check_output("rr_src3", 32'(src_log[3]), 1);
    check_output("rr_gap1", t_log[1] - t_log[0], 6);
    check_output("rr_gap2", t_log[2] - t_log[1], 6);
    check_output("rr_gap3", t_log[3] - t_log[2], 6);
    repeat (8) @(negedge clk);
    check_output("rr_idle_busy", 32'(scan_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pmp_check_sched.md
# pmp_check_sched

Sequential PMP checker and scheduler sharing one range-match engine between instruction fetch and load/store. Accepts one access request at a time via round-robin arbitration, scans PMP entries `ENTRIES_PER_BEAT` per cycle in ascending index order, and returns allow/deny plus the winning entry. Sits between the CSR file, which supplies the flattened pmpcfg/pmpaddr state, and the fetch and LSU stall/trap logic.

## Interface
- `NUM_ENTRIES`, 16, number of PMP entries; power of two, 1..16.
- `ENTRIES_PER_BEAT`, 4, entries evaluated per scan cycle; must divide `NUM_ENTRIES`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_req_addr` in 32: fetch request channel.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_req_addr` in 32, `lsu_req_we` in 1: data request channel; `we`=1 store, 0 load.
- `priv_m` in 1: 1 = machine mode, sampled at accept.
- `pmpcfg_i` in `NUM_ENTRIES*8`: entry i at bits [8i+7:8i]; bit 7 L, bits 4:3 A (OFF/TOR/NA4/NAPOT), bit 2 X, bit 1 W, bit 0 R.
- `pmpaddr_i` in `NUM_ENTRIES*32`: entry i at [32i+31:32i], physical address bits [33:2].
- `scan_busy` out 1: high in SCAN and RESP; the CSR file stalls PMP CSR writes while it is high.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_src` out 1: 0 = fetch, 1 = LSU.
- `resp_allow` out 1, `resp_matched` out 1, `resp_idx` out 4: result, match flag, and winning entry index (0 when unmatched).

## Operation
- FSM states IDLE, SCAN, RESP. Reset state IDLE.
- IDLE: `if_req_ready`/`lsu_req_ready` equal the grant. If only one valid, grant it. If both valid, grant the requester not served last. `last_src` resets to LSU, so fetch wins the first tie. On accept, latch addr, src, access type (X for fetch, W/R from `we`), and `priv_m`. Set beat=0 and go to SCAN.
- SCAN: evaluate entries beat*EPB .. beat*EPB+EPB-1.
  - OFF never matches.
  - TOR: `pmpaddr[i-1]<<2 <= addr < pmpaddr[i]<<2`, with lower bound 0 for i=0. Compare at 34 bits; addr is zero-extended.
  - NA4: `addr[31:2] == pmpaddr[29:0]`.
  - NAPOT: k = trailing ones of pmpaddr; match when addr[33:k+3] equals pmpaddr[31:k+1], with the region size 2^(k+3) bytes. pmpaddr all ones matches all addresses.
  - If any entry in the beat matches, latch the lowest-index match and go to RESP. Otherwise increment beat; after the last beat, go to RESP unmatched.
- Decision:
  - Matched, L=0, M-mode: allow.
  - Matched, otherwise: allow iff the required permission bit is set.
  - Unmatched: allow iff M-mode.
- RESP: `resp_valid`=1 with stable outputs until `resp_ready`. On handshake, update `last_src` and return to IDLE. Both readies are 0 outside IDLE.
- The block never reorders requests and holds at most one request in flight.

## Timing
- Reset values:
  - `resp_valid`, `resp_allow`, `resp_matched`, `scan_busy`, both readies: 0.
  - `resp_src`, `resp_idx`: 0.
  - Readies go combinational from valids after reset release.
- Accept at cycle T. The first beat is evaluated at T+1. A match in beat b gives `resp_valid` at T+2+b.
- Best case is T+2. Worst case, with no match, is T+1+`NUM_ENTRIES/ENTRIES_PER_BEAT` (T+5 at defaults).
- Back-to-back throughput: the next accept happens in the cycle after the response handshake (IDLE cycle).
- `resp_ready` held high still costs the IDLE cycle; there is no accept in the RESP cycle.
- Requester valid dropped before accept: no effect. Valid held across the response: re-arbitrated normally.
- `rst_n` asserted mid-scan or in RESP: immediate return to IDLE, the in-flight request is discarded, and no response is issued.
- Config inputs are only read in SCAN. Changes while `scan_busy`=1 are illegal (CSR file guarantees they do not occur).

## Configuration
- `PMP_NAPOT_EN` defined: NAPOT matching as above.
- Not defined: the NAPOT encoding is treated as OFF (never matches) and the trailing-ones logic is removed. NA4 and TOR are unaffected.

## Test plan
- Entry0 NA4 addr 0x1000>>2 with R only; LSU load 0x1000, U-mode -> `resp_allow`=1, `resp_idx`=0, `resp_valid` at T+2.
- Same config; LSU store 0x1000, U-mode -> allow=0, matched=1. Same store in M-mode with L=0 -> allow=1. Set L=1 -> allow=0.
- Entries 5 (TOR to 0x8000) and 9 (TOR 0x8000..0x9000, X) configured; fetch 0x8800, U-mode -> idx=9, allow=1, `resp_valid` at T+4.
- All OFF: fetch 0x0, U-mode -> matched=0, allow=0, valid at T+5. In M-mode -> allow=1.
- Both valid every cycle -> grants alternate IF, LSU, IF, …, starting with IF after reset.
- Entry3 NAPOT pmpaddr=0x0000_03FF (8 KiB at 0): addr 0x1FFC matches, 0x2000 does not. Without `PMP_NAPOT_EN`, neither matches. Assert `rst_n` during SCAN -> no response, readies return the next cycle.
